// File: rtl/byte_frame_feeder.sv
// -----------------------------------------------------------------------------
// byte_frame_feeder
//
// Upstream stage for the min/max averager. Collects one frame of DEPTH bytes
// from a host over a valid/ready handshake, and on a go request replays the
// frame to the averager: a one-cycle start pulse with byte 0, then one byte
// per cycle. It then holds off until the averager reports done and reopens
// for the next frame.
//
// Parameters:
//   WIDTH  data byte width in bits
//   DEPTH  bytes per frame (power of two, at least 2)
//   CNT_W  width of frame_count
//
// Ports:
//   clock        system clock, rising edge
//   reset        synchronous, active-high reset
//   in_data      host byte
//   in_valid     host byte valid
//   in_ready     feeder accepts a byte this cycle (registered)
//   go           request to stream the buffered frame (level-sampled)
//   sink_done    averager has finished the frame (level-sampled)
//   replay       (FEEDER_REPLAY_EN only) on sink_done, keep the frame and
//                return to FULL instead of FILL
//   data         byte to averager (registered, holds after the frame)
//   start        one-cycle pulse coinciding with frame byte 0
//   data_valid   data carries a frame byte this cycle
//   busy         high in every state except FILL
//   frame_count  completed frames, wraps
//
// Optional feature macro: FEEDER_REPLAY_EN (adds the replay input).
// -----------------------------------------------------------------------------
module byte_frame_feeder #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             go,
  input  logic             sink_done,
`ifdef FEEDER_REPLAY_EN
  input  logic             replay,
`endif
  output logic [WIDTH-1:0] data,
  output logic             start,
  output logic             data_valid,
  output logic             busy,
  output logic [CNT_W-1:0] frame_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Last write slot of a frame, and the read pointer value reached once the
  // final byte has been presented (one past the last slot, hence PTR_W+1 bits).
  localparam logic [PTR_W-1:0] LAST_WR = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W:0]   RD_END  = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    FULL      = 2'd1,
    STREAM    = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] wr_ptr_nxt;
  logic [PTR_W:0]   rd_ptr;
  logic [PTR_W:0]   rd_ptr_nxt;
  logic             wr_en;

  logic [WIDTH-1:0] data_nxt;
  logic             start_nxt;
  logic             data_valid_nxt;
  logic             in_ready_nxt;
  logic             busy_nxt;
  logic [CNT_W-1:0] frame_count_nxt;

  logic             replay_req;

  logic [WIDTH-1:0] mem [DEPTH];

`ifdef FEEDER_REPLAY_EN
  assign replay_req = replay;
`else
  assign replay_req = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State register (also holds pointers and the registered outputs)
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= FILL;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      in_ready    <= 1'b1;
      data        <= '0;
      start       <= 1'b0;
      data_valid  <= 1'b0;
      busy        <= 1'b0;
      frame_count <= '0;
    end else begin
      state       <= state_nxt;
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      in_ready    <= in_ready_nxt;
      data        <= data_nxt;
      start       <= start_nxt;
      data_valid  <= data_valid_nxt;
      busy        <= busy_nxt;
      frame_count <= frame_count_nxt;
    end
  end

  // NOTE: the frame buffer has no reset; a frame is always fully rewritten
  // before it can be streamed, so stale contents are never observable.
  // Writes are still suppressed on a reset edge so reset wins cleanly.
  always_ff @(posedge clock) begin
    if (wr_en && !reset) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in a combinational block gets a default first,
  // so no path through the case statement can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      FILL:      if (in_valid && (wr_ptr == LAST_WR)) state_nxt = FULL;
      FULL:      if (go)                              state_nxt = STREAM;
      STREAM:    if (rd_ptr == RD_END)                state_nxt = WAIT_DONE;
      WAIT_DONE: if (sink_done)                       state_nxt = replay_req ? FULL : FILL;
      default:                                        state_nxt = FILL;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath logic: next values for the registered outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_en           = 1'b0;
    wr_ptr_nxt      = wr_ptr;
    rd_ptr_nxt      = rd_ptr;
    data_nxt        = data;
    start_nxt       = 1'b0;
    data_valid_nxt  = 1'b0;
    frame_count_nxt = frame_count;

    case (state)
      FILL: begin
        if (in_valid) begin
          wr_en      = 1'b1;
          wr_ptr_nxt = (wr_ptr == LAST_WR) ? '0 : wr_ptr + 1'b1;
        end
      end

      FULL: begin
        if (go) begin
          data_nxt       = mem[0];
          start_nxt      = 1'b1;
          data_valid_nxt = 1'b1;
          rd_ptr_nxt     = (PTR_W + 1)'(1);
        end
      end

      STREAM: begin
        if (rd_ptr == RD_END) begin
          // Frame finished: data keeps the last byte, valid drops.
          rd_ptr_nxt = '0;
        end else begin
          data_nxt       = mem[rd_ptr[PTR_W-1:0]];
          data_valid_nxt = 1'b1;
          rd_ptr_nxt     = rd_ptr + 1'b1;
        end
      end

      WAIT_DONE: begin
        if (sink_done) begin
          frame_count_nxt = frame_count + 1'b1;
        end
      end

      default: ;
    endcase

    // Handshake/status flags follow the state being entered, so they are
    // correct on the very edge that changes state.
    in_ready_nxt = (state_nxt == FILL);
    busy_nxt     = (state_nxt != FILL);
  end

endmodule

// File: tb/tb_byte_frame_feeder.sv
// -----------------------------------------------------------------------------
// tb_byte_frame_feeder
//
// Self-checking bench for byte_frame_feeder. A queue-based behavioural model
// tracks the bytes collected for the current frame and the bytes still to be
// presented; every cycle the DUT outputs are compared against it. Directed
// sequences add hand-computed literal expectations, followed by randomized
// traffic and a 256-frame wrap run.
// -----------------------------------------------------------------------------
module tb_byte_frame_feeder;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int CNT_W = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             go;
  logic             sink_done;
  logic             replay;
  logic [WIDTH-1:0] data;
  logic             start;
  logic             data_valid;
  logic             busy;
  logic [CNT_W-1:0] frame_count;

  always #5 clock = ~clock;

  byte_frame_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .go          (go),
    .sink_done   (sink_done),
`ifdef FEEDER_REPLAY_EN
    .replay      (replay),
`endif
    .data        (data),
    .start       (start),
    .data_valid  (data_valid),
    .busy        (busy),
    .frame_count (frame_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: a frame is a list of collected bytes; streaming pops a
  // copy of that list one byte per cycle.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] frame_q [$];
  logic [WIDTH-1:0] send_q  [$];
  bit               m_loaded, m_sending, m_waiting;
  logic [WIDTH-1:0] m_data;
  bit               m_start, m_valid;
  logic [CNT_W-1:0] m_count;
  int               frames_done;

  task automatic model_edge();
    bit rep;
`ifdef FEEDER_REPLAY_EN
    rep = replay;
`else
    rep = 1'b0;
`endif
    if (reset) begin
      frame_q.delete();
      send_q.delete();
      m_loaded  = 0;
      m_sending = 0;
      m_waiting = 0;
      m_data    = '0;
      m_start   = 0;
      m_valid   = 0;
      m_count   = '0;
    end else begin
      m_start = 0;
      if (m_waiting) begin
        m_valid = 0;
        if (sink_done) begin
          m_count++;
          frames_done++;
          m_waiting = 0;
          if (rep) m_loaded = 1;
          else     frame_q.delete();
        end
      end else if (m_sending) begin
        if (send_q.size() == 0) begin
          m_valid   = 0;
          m_sending = 0;
          m_waiting = 1;
        end else begin
          m_data  = send_q.pop_front();
          m_valid = 1;
        end
      end else if (m_loaded) begin
        if (go) begin
          send_q    = frame_q;
          m_data    = send_q.pop_front();
          m_start   = 1;
          m_valid   = 1;
          m_sending = 1;
          m_loaded  = 0;
        end
      end else if (in_valid) begin
        frame_q.push_back(in_data);
        if (frame_q.size() == DEPTH) m_loaded = 1;
      end
    end
  endtask

  // One clock: model consumes the inputs sampled at the edge, then the DUT
  // outputs are compared 1 time unit later.
  task automatic step();
    bit idle;
    @(posedge clock);
    model_edge();
    #1;
    idle = !(m_loaded || m_sending || m_waiting);
    check("in_ready",    in_ready,    idle);
    check("busy",        busy,        !idle);
    check("start",       start,       m_start);
    check("data_valid",  data_valid,  m_valid);
    check("data",        data,        m_data);
    check("frame_count", frame_count, m_count);
  endtask

  logic [WIDTH-1:0] pat [DEPTH] = '{8'hFF, 8'h00, 8'h7F, 8'h80, 8'h01, 8'hFE, 8'h55, 8'hAA};

  initial begin
    int guard;
    reset     = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    go        = 1'b0;
    sink_done = 1'b0;
    replay    = 1'b0;
    frames_done = 0;

    step();
    step();
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_data", data, 0);
    check("rst_count", frame_count, 0);
    reset = 1'b0;

    // Fill 0x10..0x80 with in_valid held high.
    in_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      in_data = WIDTH'((i + 1) * 16);
      step();
    end
    check("full_in_ready", in_ready, 0);
    check("full_busy", busy, 1);

    // 0x99 offered while FULL: must not be taken.
    in_data = 8'h99;
    step();
    step();
    check("pending_in_ready", in_ready, 0);

    // Stream, with a stray sink_done mid-stream.
    go = 1'b1;
    step();
    go = 1'b0;
    check("go_start", start, 1);
    check("go_byte0", data, 8'h10);
    for (int i = 1; i < DEPTH; i++) begin
      sink_done = (i == 3);
      step();
      check("stream_byte", data, (i + 1) * 16);
      check("stream_start", start, 0);
    end
    sink_done = 1'b0;
    step();
    check("end_valid", data_valid, 0);
    check("end_hold", data, 8'h80);
    check("ignored_done_count", frame_count, 0);

    sink_done = 1'b1;
    step();
    sink_done = 1'b0;
    check("done_count", frame_count, 1);
    check("done_in_ready", in_ready, 1);

    // Pending 0x99 becomes byte 0 of the next frame.
    step();
    for (int i = 1; i < DEPTH; i++) begin
      in_data = WIDTH'($urandom);
      step();
    end
    in_valid = 1'b0;
    go = 1'b1;
    step();
    go = 1'b0;
    check("next_byte0", data, 8'h99);
    check("next_start", start, 1);

    // Reset on the 4th stream cycle.
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_valid", data_valid, 0);
    check("midrst_start", start, 0);
    check("midrst_count", frame_count, 0);
    check("midrst_in_ready", in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("midrst_quiet", data_valid, 0);
    end

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = WIDTH'($urandom);
      go        = ($urandom_range(0, 3) == 0);
      sink_done = ($urandom_range(0, 3) == 0);
      replay    = ($urandom_range(0, 2) == 0);
      reset     = ($urandom_range(0, 499) == 0);
      step();
    end

    // 256 back-to-back frames with all requests held high.
    reset = 1'b1;
    in_valid = 1'b0; go = 1'b0; sink_done = 1'b0; replay = 1'b0;
    step();
    reset = 1'b0;
    frames_done = 0;
    in_valid = 1'b1; go = 1'b1; sink_done = 1'b1;
    guard = 0;
    while (frames_done < 256 && guard < 20000) begin
      in_data = WIDTH'($urandom);
      step();
      guard++;
    end
    check("frames_256_done", frames_done, 256);
    check("wrap_count", frame_count, 0);
    in_valid = 1'b0; go = 1'b0; sink_done = 1'b0;

`ifdef FEEDER_REPLAY_EN
    // Replay: the same frame streams twice with no refill.
    reset = 1'b1;
    step();
    reset = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      in_data = pat[i];
      step();
    end
    in_valid = 1'b0;
    for (int r = 0; r < 2; r++) begin
      go = 1'b1;
      step();
      go = 1'b0;
      check("replay_start", start, 1);
      check("replay_byte", data, pat[0]);
      for (int i = 1; i < DEPTH; i++) begin
        step();
        check("replay_byte", data, pat[i]);
        check("replay_in_ready", in_ready, 0);
      end
      step();
      sink_done = 1'b1;
      replay = 1'b1;
      step();
      sink_done = 1'b0;
      replay = 1'b0;
      check("replay_in_ready", in_ready, 0);
      check("replay_count", frame_count, r + 1);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
